// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT stage controller and its twiddle selector.
package fft_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_FLUSH,
        S_DONE
    } state_t;

    function automatic int log2_pts(input int n);
        return $clog2(n);
    endfunction

    // One coefficient entry packs real (upper) and imaginary (lower) halves.
    function automatic int entry_w(input int nbits);
        return 2 * nbits;
    endfunction

    function automatic int entry_lsb(input int k, input int nbits);
        return k * entry_w(nbits);
    endfunction

endpackage

// File: rtl/fft_tw_sel.sv
// Twiddle selection: index k from stage and in-group offset, entry mux, and
// optional conjugate with saturation when FFT_STAGE_CTRL_INVERSE_EN is defined.
module fft_tw_sel
    import fft_pkg::*;
#(
    parameter int NBITS = 9,
    parameter int N     = 8,
    parameter int LOG2N = 3,
    parameter int SW    = 2
) (
    input  logic [SW-1:0]         i_stage,
    input  logic [LOG2N-1:0]      i_j,
    input  logic [NBITS*N*2-1:0]  i_coeff,
`ifdef FFT_STAGE_CTRL_INVERSE_EN
    input  logic                  i_inv,
`endif
    output logic [NBITS-1:0]      o_tw_re,
    output logic [NBITS-1:0]      o_tw_im
);

    localparam int EW = entry_w(NBITS);

    logic [SW-1:0]    w_sh;
    logic [LOG2N-1:0] w_k;
    logic [EW-1:0]    w_entry;
    logic [NBITS-1:0] w_im_f;

    // k = j * (N >> (s+1)) is a left shift by LOG2N-1-s.
    assign w_sh    = SW'(LOG2N - 1) - i_stage;
    assign w_k     = i_j << w_sh;
    assign w_entry = i_coeff[entry_lsb(int'(w_k), NBITS) +: EW];
    assign w_im_f  = w_entry[NBITS-1:0];
    assign o_tw_re = w_entry[EW-1:NBITS];

`ifdef FFT_STAGE_CTRL_INVERSE_EN
    localparam logic [NBITS-1:0] IM_MIN = {1'b1, {(NBITS-1){1'b0}}};

    // The most negative value has no positive twin; clamp it to the maximum.
    assign o_tw_im = !i_inv             ? w_im_f :
                     (w_im_f == IM_MIN) ? ~IM_MIN :
                                          (~w_im_f + NBITS'(1));
`else
    assign o_tw_im = w_im_f;
`endif

endmodule

// File: rtl/fft_stage_ctrl.sv
// Radix-2 FFT stage/butterfly sequencer with inter-stage pipeline gaps.
// Optional conjugate-twiddle mode via macro FFT_STAGE_CTRL_INVERSE_EN.
module fft_stage_ctrl
    import fft_pkg::*;
#(
    parameter  int NBITS    = 9,
    parameter  int N        = 8,
    parameter  int PIPE_LAT = 2,
    localparam int LOG2N    = log2_pts(N),
    localparam int SW       = $clog2(LOG2N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
`ifdef FFT_STAGE_CTRL_INVERSE_EN
    input  logic                  inverse,
`endif
    input  logic [NBITS*N*2-1:0]  coeff_data,
    input  logic                  bf_ready,
    output logic                  bf_valid,
    output logic [SW-1:0]         stage,
    output logic [LOG2N-1:0]      addr_a,
    output logic [LOG2N-1:0]      addr_b,
    output logic [NBITS-1:0]      tw_re,
    output logic [NBITS-1:0]      tw_im,
    output logic                  busy,
    output logic                  done
);

    localparam int BW     = LOG2N - 1;
    localparam int HALF_N = N / 2;
    localparam logic [3:0] GAP_LAST = 4'(PIPE_LAT - 1);

    state_t        r_state, w_state_nxt;
    logic [SW-1:0] r_stage, w_stage_nxt;
    logic [BW-1:0] r_b,     w_b_nxt;
    logic [3:0]    r_gap,   w_gap_nxt;
    logic          w_last_b, w_last_stage, w_gap_end;
`ifdef FFT_STAGE_CTRL_INVERSE_EN
    logic          r_inv, w_inv_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_stage <= '0;
            r_b     <= '0;
            r_gap   <= '0;
`ifdef FFT_STAGE_CTRL_INVERSE_EN
            r_inv   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_stage <= w_stage_nxt;
            r_b     <= w_b_nxt;
            r_gap   <= w_gap_nxt;
`ifdef FFT_STAGE_CTRL_INVERSE_EN
            r_inv   <= w_inv_nxt;
`endif
        end
    end

    assign w_last_b     = (r_b == BW'(HALF_N - 1));
    assign w_last_stage = (r_stage == SW'(LOG2N - 1));
    assign w_gap_end    = (r_gap == GAP_LAST);

    // b and stage advance only when leaving GAP, so the presented butterfly
    // (addresses, twiddle) stays frozen while bf_valid is low.
    always_comb begin
        w_state_nxt = r_state;
        w_stage_nxt = r_stage;
        w_b_nxt     = r_b;
        w_gap_nxt   = r_gap;
`ifdef FFT_STAGE_CTRL_INVERSE_EN
        w_inv_nxt   = r_inv;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_stage_nxt = '0;
                    w_b_nxt     = '0;
                    w_gap_nxt   = '0;
`ifdef FFT_STAGE_CTRL_INVERSE_EN
                    w_inv_nxt   = inverse;
`endif
                end
            end
            S_RUN: begin
                if (bf_ready) begin
                    if (!w_last_b) begin
                        w_b_nxt = r_b + BW'(1);
                    end else if (!w_last_stage) begin
                        if (PIPE_LAT == 0) begin
                            w_stage_nxt = r_stage + SW'(1);
                            w_b_nxt     = '0;
                        end else begin
                            w_state_nxt = S_GAP;
                            w_gap_nxt   = '0;
                        end
                    end else begin
                        w_state_nxt = (PIPE_LAT == 0) ? S_DONE : S_FLUSH;
                        w_gap_nxt   = '0;
                    end
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_state_nxt = S_RUN;
                    w_stage_nxt = r_stage + SW'(1);
                    w_b_nxt     = '0;
                    w_gap_nxt   = '0;
                end else begin
                    w_gap_nxt = r_gap + 4'd1;
                end
            end
            S_FLUSH: begin
                if (w_gap_end) begin
                    w_state_nxt = S_DONE;
                    w_gap_nxt   = '0;
                end else begin
                    w_gap_nxt = r_gap + 4'd1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bf_valid = (r_state == S_RUN);
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign stage    = r_stage;

    logic [LOG2N-1:0] w_b_ext, w_half, w_j, w_blk, w_a;

    assign w_b_ext = {1'b0, r_b};
    assign w_half  = LOG2N'(1) << r_stage;
    assign w_j     = w_b_ext & (w_half - LOG2N'(1));
    assign w_blk   = w_b_ext >> r_stage;
    assign w_a     = ((w_blk << r_stage) << 1) | w_j;
    assign addr_a  = w_a;
    assign addr_b  = w_a | w_half;

    fft_tw_sel #(
        .NBITS (NBITS),
        .N     (N),
        .LOG2N (LOG2N),
        .SW    (SW)
    ) u_tw_sel (
        .i_stage (r_stage),
        .i_j     (w_j),
        .i_coeff (coeff_data),
`ifdef FFT_STAGE_CTRL_INVERSE_EN
        .i_inv   (r_inv),
`endif
        .o_tw_re (tw_re),
        .o_tw_im (tw_im)
    );

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Self-checking bench for fft_stage_ctrl against a butterfly-schedule model.
// Exercises conjugate mode when FFT_STAGE_CTRL_INVERSE_EN is defined.
module tb_fft_stage_ctrl;

    localparam int NBITS    = 9;
    localparam int N        = 8;
    localparam int PIPE_LAT = 2;
    localparam int LOG2N    = 3;
    localparam int HALF     = N / 2;
    localparam int TOTAL    = LOG2N * HALF;
    localparam int RUN_LAT  = LOG2N * HALF + LOG2N * PIPE_LAT + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic bf_ready = 1'b0;
    logic [NBITS*N*2-1:0] coeff_data = '0;
    logic bf_valid, busy, done;
    logic [1:0] stage;
    logic [2:0] addr_a, addr_b;
    logic [NBITS-1:0] tw_re, tw_im;
`ifdef FFT_STAGE_CTRL_INVERSE_EN
    logic inverse = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int tb_re [N];
    int tb_im [N];
    int e_s = 0, e_a = 0, e_b = 1, e_k = 0;
    bit m_inv = 1'b0;
    int dc;

    always #5 clk = ~clk;

    fft_stage_ctrl #(.NBITS(NBITS), .N(N), .PIPE_LAT(PIPE_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
`ifdef FFT_STAGE_CTRL_INVERSE_EN
        .inverse    (inverse),
`endif
        .coeff_data (coeff_data),
        .bf_ready   (bf_ready),
        .bf_valid   (bf_valid),
        .stage      (stage),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .tw_re      (tw_re),
        .tw_im      (tw_im),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input int k, input int re, input int im);
        tb_re[k] = re;
        tb_im[k] = im;
        coeff_data[k*2*NBITS +: 2*NBITS] = {9'(re), 9'(im)};
    endtask

    task automatic rand_table;
        for (int k = 0; k < N; k++)
            set_entry(k, int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256);
    endtask

    function automatic int exp_im(input int raw);
        if (m_inv) return (raw == -256) ? 255 : -raw;
        return raw;
    endfunction

    // Butterfly number idx in run order -> stage, addresses, twiddle index.
    task automatic set_bf(input int idx);
        int b, half, j;
        e_s  = idx / HALF;
        b    = idx % HALF;
        half = 1 << e_s;
        j    = b % half;
        e_a  = (b / half) * 2 * half + j;
        e_b  = e_a + half;
        e_k  = j * (N >> (e_s + 1));
    endtask

    task automatic chk_outs(input string p);
        logic [8:0] xr, xi;
        xr = 9'(tb_re[e_k]);
        xi = 9'(exp_im(tb_im[e_k]));
        chk({p, "_stage"},  32'(stage),  32'(e_s));
        chk({p, "_addr_a"}, 32'(addr_a), 32'(e_a));
        chk({p, "_addr_b"}, 32'(addr_b), 32'(e_b));
        chk({p, "_tw_re"},  32'(tw_re),  32'(xr));
        chk({p, "_tw_im"},  32'(tw_im),  32'(xi));
    endtask

    task automatic chk_idle(input string p);
        chk({p, "_valid"}, 32'(bf_valid), 32'd0);
        chk({p, "_busy"},  32'(busy),     32'd0);
        chk({p, "_done"},  32'(done),     32'd0);
        chk_outs(p);
    endtask

    task automatic run(input int stall_at, input int stall_len, input bit rnd_ready,
                       input bit poke, input int abort_at, input bit inv, output int done_cyc);
        int idx, idle, cyc, stalls;
        bit fin, rdy;
        idx = 0; idle = 0; stalls = 0; fin = 1'b0; done_cyc = -1;
        start = 1'b1;
        m_inv = inv;
`ifdef FFT_STAGE_CTRL_INVERSE_EN
        inverse = inv;
`endif
        step;
        start = 1'b0;
        cyc = 1;
        while (!fin && cyc < 300) begin
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                step;
                rst_n = 1'b1;
                e_s = 0; e_a = 0; e_b = 1; e_k = 0; m_inv = 1'b0;
                chk_idle("abort");
                repeat (3) step;
                chk("abort_no_resume", 32'(busy), 32'd0);
                done_cyc = 0;
                return;
            end
            chk("run_busy", 32'(busy), 32'd1);
            if (idx < TOTAL && idle == 0) begin
                set_bf(idx);
                chk("run_valid", 32'(bf_valid), 32'd1);
                chk("run_done", 32'(done), 32'd0);
                chk_outs("run");
                rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (idx == stall_at && stalls < stall_len) begin
                    rdy = 1'b0;
                    stalls++;
                end
                bf_ready = rdy;
                if (rdy) begin
                    idx++;
                    if (idx % HALF == 0) idle = PIPE_LAT;
                end
            end else if (idle > 0) begin
                chk("gap_valid", 32'(bf_valid), 32'd0);
                chk("gap_done", 32'(done), 32'd0);
                chk_outs("gap");
                idle--;
                bf_ready = 1'($urandom_range(0, 1));
            end else begin
                chk("done_valid", 32'(bf_valid), 32'd0);
                chk("done_pulse", 32'(done), 32'd1);
                chk_outs("done");
                done_cyc = cyc;
                fin = 1'b1;
            end
            if (poke) begin
                start = 1'($urandom_range(0, 1));
`ifdef FFT_STAGE_CTRL_INVERSE_EN
                inverse = 1'($urandom_range(0, 1));
`endif
            end
            step;
            cyc++;
        end
        start = 1'b0;
        if (!fin) chk("run_timeout", 32'd0, 32'd1);
        chk_idle("post");
        repeat (3) begin
            step;
            chk("post_idle_busy", 32'(busy), 32'd0);
            chk("post_idle_done", 32'(done), 32'd0);
        end
    endtask

    initial begin
        rand_table();
        set_entry(0, 4, 0);
        repeat (2) step;
        chk_idle("reset");
        chk("reset_tw_re4", 32'(tw_re), 32'd4);
        rst_n = 1'b1;
        step;

        run(-1, 0, 1'b0, 1'b0, -1, 1'b0, dc);
        chk("latency", 32'(dc), 32'(RUN_LAT));

        run(6, 3, 1'b0, 1'b0, -1, 1'b0, dc);
        chk("stall_latency", 32'(dc), 32'(RUN_LAT + 3));

        run(-1, 0, 1'b0, 1'b1, -1, 1'b0, dc);
        chk("poke_latency", 32'(dc), 32'(RUN_LAT));

        run(-1, 0, 1'b0, 1'b0, 9, 1'b0, dc);
        run(-1, 0, 1'b0, 1'b0, -1, 1'b0, dc);
        chk("after_abort_latency", 32'(dc), 32'(RUN_LAT));

        for (int r = 0; r < 4; r++) begin
            rand_table();
            run(-1, 0, 1'b1, 1'b1, -1, 1'b0, dc);
        end

`ifdef FFT_STAGE_CTRL_INVERSE_EN
        rand_table();
        set_entry(1, 17, -256);
        set_entry(2, -5, -3);
        run(-1, 0, 1'b0, 1'b1, -1, 1'b1, dc);
        chk("inv_latency", 32'(dc), 32'(RUN_LAT));
        rand_table();
        set_entry(3, 9, -256);
        run(-1, 0, 1'b1, 1'b1, -1, 1'b1, dc);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
